// File: rtl/gcd_pkg.sv
// Shared types for the GCD job scheduler: state encoding, default widths and the FIFO entry.
package gcd_pkg;

    localparam int GCD_DATA_W = 8;
    localparam int GCD_TAG_W  = 4;

    // IDLE: wait for a job | ISSUE: pulse START | WAIT: engine busy, watchdog runs | RESULT: hold output
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_t;

    typedef struct packed {
        logic [GCD_DATA_W-1:0] a;
        logic [GCD_DATA_W-1:0] b;
        logic [GCD_TAG_W-1:0]  tag;
    } fifo_entry_t;

endpackage

// File: rtl/gcd_job_scheduler_if.sv
// Stream and engine handshakes for the GCD job scheduler.
interface gcd_in_if #(
    parameter int DATA_W = gcd_pkg::GCD_DATA_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;

    modport master (output valid, a, b, input ready);
    modport slave  (input valid, a, b, output ready);
endinterface

interface gcd_eng_if #(
    parameter int DATA_W = gcd_pkg::GCD_DATA_W
);
    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              done;
    logic [DATA_W-1:0] y;
    logic              error;

    modport master (output start, a, b, input done, y, error);
    modport slave  (input start, a, b, output done, y, error);
endinterface

interface gcd_out_if #(
    parameter int DATA_W = gcd_pkg::GCD_DATA_W,
    parameter int TAG_W  = gcd_pkg::GCD_TAG_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] y;
    logic              error;
    logic              timeout;
    logic [TAG_W-1:0]  tag;

    modport master (output valid, y, error, timeout, tag, input ready);
    modport slave  (input valid, y, error, timeout, tag, output ready);
endinterface

// File: rtl/gcd_op_fifo.sv
// Synchronous operand FIFO; full is registered so the upstream ready has no input-to-output path.
module gcd_op_fifo
    import gcd_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fifo_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  entry_t                   wdata_i,
    output entry_t                   rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/gcd_job_scheduler.sv
// Queues operand pairs, runs one GCD job at a time under a watchdog, and returns tagged results in order.
module gcd_job_scheduler
    import gcd_pkg::*;
#(
    parameter int DATA_W  = GCD_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = GCD_TAG_W,
    parameter int TIMEOUT = 64
) (
    input  logic      clk_i,
    input  logic      rst_i,
    gcd_in_if.slave   in_if,
    gcd_eng_if.master eng_if,
    gcd_out_if.master out_if,
    output logic      busy_o
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    // Abort on the WAIT cycle whose incremented count reaches TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } job_t;

    job_t             push_entry, head_entry;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic [TAG_W-1:0] tag_cnt_q;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] job_a_q, job_a_d, job_b_q, job_b_d;
    logic [TAG_W-1:0]  job_tag_q, job_tag_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_y_q, out_y_d;
    logic              out_err_q, out_err_d;
    logic              out_to_q, out_to_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    assign fifo_push   = in_if.valid && !fifo_full;
    assign in_if.ready = !fifo_full;
    assign push_entry  = '{a: in_if.a, b: in_if.b, tag: tag_cnt_q};

    gcd_op_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (job_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          tag_cnt_q <= '0;
        else if (fifo_push) tag_cnt_q <= tag_cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        job_a_d     = job_a_q;
        job_b_d     = job_b_q;
        job_tag_d   = job_tag_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_err_d   = out_err_q;
        out_to_d    = out_to_q;
        out_tag_d   = out_tag_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty && !out_valid_q) begin
                    fifo_pop  = 1'b1;
                    job_a_d   = head_entry.a;
                    job_b_d   = head_entry.b;
                    job_tag_d = head_entry.tag;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (eng_if.done) begin
                    out_valid_d = 1'b1;
                    out_y_d     = eng_if.y;
                    out_err_d   = eng_if.error;
                    out_to_d    = 1'b0;
                    out_tag_d   = job_tag_q;
                    state_d     = RESULT;
                end else if (wd_q == WD_LAST) begin
                    out_valid_d = 1'b1;
                    out_y_d     = '0;
                    out_err_d   = 1'b1;
                    out_to_d    = 1'b1;
                    out_tag_d   = job_tag_q;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                if (out_if.ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            job_a_q     <= '0;
            job_b_q     <= '0;
            job_tag_q   <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_err_q   <= 1'b0;
            out_to_q    <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            job_a_q     <= job_a_d;
            job_b_q     <= job_b_d;
            job_tag_q   <= job_tag_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_err_q   <= out_err_d;
            out_to_q    <= out_to_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign eng_if.start   = (state_q == ISSUE);
    assign eng_if.a       = job_a_q;
    assign eng_if.b       = job_b_q;
    assign out_if.valid   = out_valid_q;
    assign out_if.y       = out_y_q;
    assign out_if.error   = out_err_q;
    assign out_if.timeout = out_to_q;
    assign out_if.tag     = out_tag_q;
    assign busy_o         = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Randomised bench for gcd_job_scheduler with a behavioural GCD engine and an in-order result model.
module tb_gcd_job_scheduler;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 64;
    localparam int LATE    = TIMEOUT + 3;

    typedef struct {
        logic [7:0] y;
        logic       err;
        logic       to;
        logic [3:0] tag;
        int         cyc;
        int         scyc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    gcd_in_if  #(.DATA_W(DATA_W))                in_if ();
    gcd_eng_if #(.DATA_W(DATA_W))                eng_if ();
    gcd_out_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) out_if ();

    gcd_job_scheduler #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .in_if  (in_if),
        .eng_if (eng_if),
        .out_if (out_if),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    res_t obs_q[$];
    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   last_start_cyc = 0;
    int   stab_err = 0;
    int   hold_err = 0;
    int   model_starts = 0;
    int   late_idx = -1;
    int   tag_m = 0;

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // Behavioural GCD engine: answers each START after a short random delay, or very late on request.
    initial begin
        logic [7:0] ma, mb;
        int d;
        eng_if.done  = 1'b0;
        eng_if.y     = '0;
        eng_if.error = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_if.start === 1'b1) begin
                ma = eng_if.a;
                mb = eng_if.b;
                d  = (model_starts == late_idx) ? LATE : int'($urandom_range(1, 6));
                model_starts++;
                repeat (d) @(negedge clk);
                eng_if.y     = ref_gcd(ma, mb);
                eng_if.error = (ma == 0) || (mb == 0);
                eng_if.done  = 1'b1;
                @(negedge clk);
                eng_if.done  = 1'b0;
                eng_if.y     = '0;
                eng_if.error = 1'b0;
            end
        end
    end

    // Observer: records each new result, checks held outputs and job operand stability.
    initial begin
        logic pv, pacc, jon;
        logic [7:0] la, lb;
        res_t held;
        pv = 0; pacc = 0; jon = 0; la = 0; lb = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pv = 0; pacc = 0; jon = 0;
            end else begin
                if (eng_if.start) begin
                    start_cnt++;
                    last_start_cyc = cyc;
                    jon = 1; la = eng_if.a; lb = eng_if.b;
                end else if (jon) begin
                    if (out_if.valid) jon = 0;
                    else if (eng_if.a !== la || eng_if.b !== lb) stab_err++;
                end
                if (out_if.valid) begin
                    if (pv && !pacc) begin
                        if (out_if.y !== held.y || out_if.error !== held.err ||
                            out_if.timeout !== held.to || out_if.tag !== held.tag) hold_err++;
                    end else begin
                        held.y    = out_if.y;
                        held.err  = out_if.error;
                        held.to   = out_if.timeout;
                        held.tag  = out_if.tag;
                        held.cyc  = cyc;
                        held.scyc = last_start_cyc;
                        obs_q.push_back(held);
                    end
                end
                pv   = out_if.valid;
                pacc = out_if.valid && out_if.ready;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input bit to_exp);
        int t = 0;
        res_t e;
        @(negedge clk);
        in_if.valid = 1'b1;
        in_if.a     = a;
        in_if.b     = b;
        while (in_if.ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL push_accept got no IN_READY within 3000 cycles, required accept");
        end else begin
            e.y   = to_exp ? 8'd0 : ref_gcd(a, b);
            e.err = to_exp || (a == 0) || (b == 0);
            e.to  = to_exp;
            e.tag = 4'(tag_m);
            e.cyc = 0; e.scyc = 0;
            tag_m = (tag_m + 1) % 16;
            exp_q.push_back(e);
        end
    endtask

    task automatic in_idle();
        @(negedge clk);
        in_if.valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, input string nm);
        int t = 0;
        while (obs_q.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #2;
        if (obs_q.size() < n) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_wait got %0d results, required %0d", nm, obs_q.size(), n);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_if.valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tag_m = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        in_if.valid = 1'b0; in_if.a = '0; in_if.b = '0; out_if.ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if ({out_if.valid, eng_if.start, eng_if.a, eng_if.b, out_if.y, out_if.error,
             out_if.timeout, out_if.tag, busy, in_if.ready} !== {36'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_outputs got valid=%b start=%b a=%0d b=%0d y=%0d err=%b to=%b tag=%0d busy=%b ready=%b, required all 0 and ready=1",
                     out_if.valid, eng_if.start, eng_if.a, eng_if.b, out_if.y, out_if.error,
                     out_if.timeout, out_if.tag, busy, in_if.ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_if.ready, busy, out_if.valid, eng_if.start} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_release got ready=%b busy=%b valid=%b start=%b, required 1 0 0 0",
                     in_if.ready, busy, out_if.valid, eng_if.start);
        end
    endtask

    task automatic test_reset_mid_job();
        int s0 = start_cnt;
        int t = 0;
        out_if.ready = 1'b1;
        late_idx = model_starts;
        push(8'd21, 8'd6, 1'b0);
        in_idle();
        while (start_cnt == s0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (start_cnt - s0 !== 1) begin
            n_bad++;
            $display("FAIL midjob_start got %0d starts, required 1", start_cnt - s0);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_if.valid, eng_if.start, eng_if.a, eng_if.b, out_if.y, out_if.error,
             out_if.timeout, out_if.tag, busy, in_if.ready} !== {36'h0, 1'b1}) begin
            n_bad++;
            $display("FAIL midjob_reset got valid=%b start=%b a=%0d b=%0d y=%0d err=%b to=%b tag=%0d busy=%b ready=%b, required all 0 and ready=1",
                     out_if.valid, eng_if.start, eng_if.a, eng_if.b, out_if.y, out_if.error,
                     out_if.timeout, out_if.tag, busy, in_if.ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tag_m = 0;
        exp_q.delete();
        obs_q.delete();
        repeat (TIMEOUT + 15) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || out_if.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midjob_late_done got %0d results valid=%b, required 0 results", obs_q.size(), out_if.valid);
        end
    endtask

    task automatic test_basic();
        int s0 = start_cnt;
        int st0 = stab_err;
        out_if.ready = 1'b1;
        push(8'd21, 8'd6, 1'b0);
        push(8'd75, 8'd60, 1'b0);
        in_idle();
        wait_obs(2, 400, "basic");
        for (int i = 0; i < 2; i++) begin
            res_t o, e;
            n_cmp++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL basic_result[%0d] got no result, required one", i);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if ({o.y, o.err, o.to, o.tag} !== {e.y, e.err, e.to, e.tag} || o.tag !== 4'(i)) begin
                    n_bad++;
                    $display("FAIL basic_result[%0d] got y=%0d err=%b to=%b tag=%0d, required y=%0d err=%b to=%b tag=%0d",
                             i, o.y, o.err, o.to, o.tag, e.y, e.err, e.to, i);
                end
            end
        end
        n_cmp++;
        if (start_cnt - s0 !== 2) begin
            n_bad++;
            $display("FAIL basic_starts got %0d START pulses, required 2", start_cnt - s0);
        end
        n_cmp++;
        if (stab_err !== st0) begin
            n_bad++;
            $display("FAIL basic_operand_hold got %0d changes during WAIT, required 0", stab_err - st0);
        end
    endtask

    task automatic test_error();
        res_t o, e;
        out_if.ready = 1'b1;
        push(8'd7, 8'd0, 1'b0);
        in_idle();
        wait_obs(1, 200, "error");
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL error_result got no result, required one");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.y, o.err, o.to, o.tag} !== {e.y, e.err, e.to, e.tag} || o.err !== 1'b1 || o.to !== 1'b0) begin
                n_bad++;
                $display("FAIL error_result got y=%0d err=%b to=%b tag=%0d, required y=%0d err=1 to=0 tag=%0d",
                         o.y, o.err, o.to, o.tag, e.y, e.tag);
            end
        end
    endtask

    task automatic test_backpressure();
        int s0 = start_cnt;
        int h0 = hold_err;
        out_if.ready = 1'b0;
        push(8'd8, 8'd29, 1'b0);
        push(8'd103, 8'd103, 1'b0);
        push(8'd99, 8'd11, 1'b0);
        for (int i = 0; i < 2; i++) push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
        in_idle();
        repeat (30) @(negedge clk);
        n_cmp++;
        if (in_if.ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_full got ready=%b busy=%b, required ready=0 busy=1", in_if.ready, busy);
        end
        n_cmp++;
        if (out_if.valid !== 1'b1 || out_if.y !== 8'd1 || start_cnt - s0 !== 1) begin
            n_bad++;
            $display("FAIL bp_hold got valid=%b y=%0d starts=%0d, required valid=1 y=1 starts=1",
                     out_if.valid, out_if.y, start_cnt - s0);
        end
        fork
            begin
                for (int i = 0; i < 2; i++) push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
                in_idle();
            end
            begin
                repeat (5) @(negedge clk);
                out_if.ready = 1'b1;
            end
        join
        wait_obs(7, 2000, "bp");
        for (int i = 0; i < 7; i++) begin
            res_t o, e;
            n_cmp++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL bp_result[%0d] got no result, required one", i);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if ({o.y, o.err, o.to, o.tag} !== {e.y, e.err, e.to, e.tag}) begin
                    n_bad++;
                    $display("FAIL bp_result[%0d] got y=%0d err=%b to=%b tag=%0d, required y=%0d err=%b to=%b tag=%0d",
                             i, o.y, o.err, o.to, o.tag, e.y, e.err, e.to, e.tag);
                end
            end
        end
        n_cmp++;
        if (hold_err !== h0) begin
            n_bad++;
            $display("FAIL bp_output_stable got %0d changes while held, required 0", hold_err - h0);
        end
    endtask

    task automatic test_timeout();
        res_t o, e;
        int h0 = hold_err;
        out_if.ready = 1'b0;
        late_idx = model_starts;
        push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b1);
        push(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
        in_idle();
        wait_obs(1, TIMEOUT + 40, "timeout");
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL timeout_result got no result, required one");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.y, o.err, o.to, o.tag} !== {e.y, e.err, e.to, e.tag}) begin
                n_bad++;
                $display("FAIL timeout_result got y=%0d err=%b to=%b tag=%0d, required y=0 err=1 to=1 tag=%0d",
                         o.y, o.err, o.to, o.tag, e.tag);
            end
            n_cmp++;
            if (o.cyc - o.scyc !== TIMEOUT) begin
                n_bad++;
                $display("FAIL timeout_latency got %0d cycles START to OUT_VALID, required %0d", o.cyc - o.scyc, TIMEOUT);
            end
        end
        repeat (12) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || out_if.valid !== 1'b1 || out_if.timeout !== 1'b1 || hold_err !== h0) begin
            n_bad++;
            $display("FAIL timeout_late_done got extra=%0d valid=%b to=%b holderr=%0d, required 0 1 1 0",
                     obs_q.size(), out_if.valid, out_if.timeout, hold_err - h0);
        end
        out_if.ready = 1'b1;
        wait_obs(1, 300, "timeout_next");
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL timeout_next_result got no result, required one");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.y, o.err, o.to, o.tag} !== {e.y, e.err, e.to, e.tag}) begin
                n_bad++;
                $display("FAIL timeout_next_result got y=%0d err=%b to=%b tag=%0d, required y=%0d err=%b to=%b tag=%0d",
                         o.y, o.err, o.to, o.tag, e.y, e.err, e.to, e.tag);
            end
        end
    endtask

    task automatic test_tag_wrap();
        apply_reset();
        out_if.ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0);
        in_idle();
        wait_obs(17, 3000, "tagwrap");
        for (int i = 0; i < 17; i++) begin
            res_t o, e;
            n_cmp++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL tagwrap_result[%0d] got no result, required one", i);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if ({o.y, o.err, o.to, o.tag} !== {e.y, e.err, e.to, e.tag} || o.tag !== 4'(i % 16)) begin
                    n_bad++;
                    $display("FAIL tagwrap_result[%0d] got y=%0d err=%b tag=%0d, required y=%0d err=%b tag=%0d",
                             i, o.y, o.err, o.tag, e.y, e.err, i % 16);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_job();
        test_basic();
        test_error();
        test_backpressure();
        test_timeout();
        test_tag_wrap();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
